// File: rtl/vthernet_pkg.sv
// vthernet_pkg: shared UDP header offsets, field width and receive FSM state encoding.
package vthernet_pkg;
    localparam int W16         = 16;
    localparam int UDP_HDR_LEN = 8;
    localparam int UDP_SRC_OFF = 0;
    localparam int UDP_DST_OFF = 2;
    localparam int UDP_LEN_OFF = 4;
    localparam int UDP_CKS_OFF = 6;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } udp_state_t;
endpackage

// File: rtl/vthernet_port_match.sv
// vthernet_port_match: combinational listening-port lookup; the lowest enabled matching channel wins.
module vthernet_port_match import vthernet_pkg::*; #(
    parameter int NUM_PORTS = 4,
    parameter int CH_W      = 2
) (
    input  logic [W16-1:0]           i_dst,
    input  logic [NUM_PORTS*W16-1:0] i_port_list,
    input  logic [NUM_PORTS-1:0]     i_port_en,
    output logic                     o_hit,
    output logic [CH_W-1:0]          o_ch
);
    always_comb begin
        o_hit = 1'b0;
        o_ch  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (i_port_en[i] && i_port_list[W16*i +: W16] == i_dst) begin
                o_hit = 1'b1;
                o_ch  = CH_W'(i);
            end
    end
endmodule

// File: rtl/vthernet_rx_udp_demux.sv
// vthernet_rx_udp_demux: UDP header parse, port demux and bounded payload streaming.
// Optional saturating frame/error counters under RX_UDP_STATS_EN.
module vthernet_rx_udp_demux import vthernet_pkg::*; #(
    parameter int NUM_PORTS = 4,
    parameter int CH_W      = 2,
    parameter int ADDR_W    = 11
) (
    input  logic                     RX_CLK,
    input  logic                     rst,
    input  logic                     func_en,
    input  logic [NUM_PORTS*W16-1:0] port_list,
    input  logic [NUM_PORTS-1:0]     port_en,
    input  logic                     rx_ipv4_data_v,
    input  logic [7:0]               rx_ipv4_data,
    input  logic                     rx_ipv4_irq,
    output logic                     rx_udp_data_v,
    output logic [7:0]               rx_udp_data,
    output logic [CH_W-1:0]          rx_udp_ch,
    output logic [ADDR_W-1:0]        rx_udp_addr,
    output logic [W16-1:0]           rx_src_port,
    output logic [W16-1:0]           rx_udp_len,
    output logic [NUM_PORTS-1:0]     rx_udp_irq,
    output logic                     rx_udp_err
`ifdef RX_UDP_STATS_EN
    ,
    output logic [NUM_PORTS*W16-1:0] rx_udp_frame_cnt,
    output logic [W16-1:0]           rx_udp_err_cnt
`endif
);
    udp_state_t r_state, w_state, w_sb;
    logic [2:0]            r_hdr_cnt;
    logic [8*UDP_CKS_OFF-1:0] r_hdr;
    logic [W16-1:0]        r_rem, w_rem_n, w_dst, w_len, w_src;
    logic [ADDR_W:0]       r_addr;
    logic                  r_ovf, w_ovf_n, w_hit, w_cap, w_last_hdr, w_accept, w_beat, w_ovf_set, w_done, w_err;
    logic [CH_W-1:0]       w_mch, w_ch_n;

    // Only bytes 0..5 are kept; at byte 7 they sit fully aligned in r_hdr.
    assign w_src      = r_hdr[8*(UDP_CKS_OFF-UDP_SRC_OFF)-1 -: W16];
    assign w_dst      = r_hdr[8*(UDP_CKS_OFF-UDP_DST_OFF)-1 -: W16];
    assign w_len      = r_hdr[8*(UDP_CKS_OFF-UDP_LEN_OFF)-1 -: W16];
    assign w_cap      = rx_ipv4_data_v && (r_state == ST_HDR || (r_state == ST_IDLE && func_en));
    assign w_last_hdr = r_state == ST_HDR && rx_ipv4_data_v && r_hdr_cnt == 3'(UDP_HDR_LEN - 1);
    assign w_accept   = w_last_hdr && w_hit && w_len >= W16'(UDP_HDR_LEN);
    assign w_beat     = r_state == ST_PAYLOAD && rx_ipv4_data_v && r_rem != '0 && !r_addr[ADDR_W];
    assign w_ovf_set  = r_state == ST_PAYLOAD && rx_ipv4_data_v && r_rem != '0 && r_addr[ADDR_W];
    assign w_rem_n    = w_accept ? w_len - W16'(UDP_HDR_LEN) : r_rem - {{(W16-1){1'b0}}, w_beat};
    assign w_ovf_n    = !w_accept && (r_ovf || w_ovf_set);
    assign w_ch_n     = w_accept ? w_mch : rx_udp_ch;

    vthernet_port_match #(.NUM_PORTS(NUM_PORTS), .CH_W(CH_W)) u_match (
        .i_dst       (w_dst),
        .i_port_list (port_list),
        .i_port_en   (port_en),
        .o_hit       (w_hit),
        .o_ch        (w_mch)
    );

    // The byte of this cycle is applied first (w_sb); an end-of-datagram then judges the result.
    always_comb begin
        w_sb = r_state;
        if (r_state == ST_IDLE && rx_ipv4_data_v && func_en) w_sb = ST_HDR;
        if (w_last_hdr) w_sb = w_accept ? ST_PAYLOAD : ST_DROP;
        w_state = w_sb;
        w_done  = 1'b0;
        w_err   = w_last_hdr && w_hit && w_len < W16'(UDP_HDR_LEN);
        if (rx_ipv4_irq && r_state != ST_IDLE) begin
            w_state = ST_IDLE;
            w_done  = w_sb == ST_PAYLOAD && w_rem_n == '0 && !w_ovf_n;
            w_err   = w_err || w_sb == ST_HDR || (w_sb == ST_PAYLOAD && !w_done);
        end
    end

    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hdr_cnt     <= '0;
            r_hdr         <= '0;
            r_rem         <= '0;
            r_addr        <= '0;
            r_ovf         <= 1'b0;
            rx_udp_data_v <= 1'b0;
            rx_udp_data   <= '0;
            rx_udp_ch     <= '0;
            rx_udp_addr   <= '0;
            rx_src_port   <= '0;
            rx_udp_len    <= '0;
            rx_udp_irq    <= '0;
            rx_udp_err    <= 1'b0;
        end else begin
            r_state <= w_state;
            if (w_cap) r_hdr_cnt <= r_state == ST_IDLE ? 3'd1 : r_hdr_cnt + 3'd1;
            if (w_cap && (r_state == ST_IDLE || r_hdr_cnt < 3'(UDP_CKS_OFF)))
                r_hdr <= {r_hdr[8*UDP_CKS_OFF-9:0], rx_ipv4_data};
            r_rem         <= w_rem_n;
            r_ovf         <= w_ovf_n;
            r_addr        <= w_accept ? '0 : r_addr + {{ADDR_W{1'b0}}, w_beat};
            rx_udp_ch     <= w_ch_n;
            rx_udp_data_v <= w_beat;
            if (w_beat) rx_udp_data <= rx_ipv4_data;
            if (w_beat) rx_udp_addr <= r_addr[ADDR_W-1:0];
            if (w_accept) rx_src_port <= w_src;
            if (w_accept) rx_udp_len <= w_len;
            rx_udp_irq    <= w_done ? NUM_PORTS'(1) << w_ch_n : '0;
            rx_udp_err    <= w_err;
        end
    end

`ifdef RX_UDP_STATS_EN
    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) begin
            rx_udp_frame_cnt <= '0;
            rx_udp_err_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (rx_udp_irq[i] && rx_udp_frame_cnt[W16*i +: W16] != 16'hFFFF)
                    rx_udp_frame_cnt[W16*i +: W16] <= rx_udp_frame_cnt[W16*i +: W16] + 16'd1;
            if (rx_udp_err && rx_udp_err_cnt != 16'hFFFF) rx_udp_err_cnt <= rx_udp_err_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vthernet_rx_udp_demux.sv
// tb_vthernet_rx_udp_demux: table vectors plus random datagrams on two instances (ADDR_W 11 and 4).
module tb_vthernet_rx_udp_demux;
    logic        clk = 1'b0;
    logic        rst, func_en, v, irq;
    logic [7:0]  d;
    logic [3:0]  port_en;
    logic [63:0] port_list = {16'hBEEF, 16'h0050, 16'h0050, 16'h1234};

    logic a_v, a_err, b_v, b_err;
    logic [7:0] a_d, b_d;
    logic [1:0] a_ch, b_ch;
    logic [10:0] a_addr;
    logic [3:0] b_addr, a_irq, b_irq;
    logic [15:0] a_src, a_len, b_src, b_len;
`ifdef RX_UDP_STATS_EN
    logic [63:0] a_fc, b_fc;
    logic [15:0] a_ec, b_ec;
`endif

    always #5 clk = ~clk;

    vthernet_rx_udp_demux #(.NUM_PORTS(4), .CH_W(2), .ADDR_W(11)) dut_a (
        .RX_CLK(clk), .rst(rst), .func_en(func_en), .port_list(port_list), .port_en(port_en),
        .rx_ipv4_data_v(v), .rx_ipv4_data(d), .rx_ipv4_irq(irq),
        .rx_udp_data_v(a_v), .rx_udp_data(a_d), .rx_udp_ch(a_ch), .rx_udp_addr(a_addr),
        .rx_src_port(a_src), .rx_udp_len(a_len), .rx_udp_irq(a_irq), .rx_udp_err(a_err)
`ifdef RX_UDP_STATS_EN
        , .rx_udp_frame_cnt(a_fc), .rx_udp_err_cnt(a_ec)
`endif
    );

    vthernet_rx_udp_demux #(.NUM_PORTS(4), .CH_W(2), .ADDR_W(4)) dut_b (
        .RX_CLK(clk), .rst(rst), .func_en(func_en), .port_list(port_list), .port_en(port_en),
        .rx_ipv4_data_v(v), .rx_ipv4_data(d), .rx_ipv4_irq(irq),
        .rx_udp_data_v(b_v), .rx_udp_data(b_d), .rx_udp_ch(b_ch), .rx_udp_addr(b_addr),
        .rx_src_port(b_src), .rx_udp_len(b_len), .rx_udp_irq(b_irq), .rx_udp_err(b_err)
`ifdef RX_UDP_STATS_EN
        , .rx_udp_frame_cnt(b_fc), .rx_udp_err_cnt(b_ec)
`endif
    );

    typedef struct {
        int beats; logic [3:0] irqv; int err; logic acc; logic [1:0] ch;
    } res_t;
    typedef struct {
        logic [3:0] pen; logic [15:0] dst, len; int nhdr, npay, fe; logic same;
        int e_beats; logic [3:0] e_irq; int e_err; logic [1:0] e_ch;
    } vec_t;

    int errors = 0, checks = 0;
    logic [31:0] qa[$], qb[$];
    int na_irq = 0, nb_irq = 0, na_err = 0, nb_err = 0;
    logic [3:0] la_irq = '0, lb_irq = '0;
    int ba_q, bb_q, ba_i, bb_i, ba_e, bb_e;
    logic [7:0] pl[$];
    logic [7:0] pat[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [1:0] m_ch = '0;
    logic [15:0] m_src = '0, m_len = '0;
    vec_t tv[14];

    always @(negedge clk) begin
        if (a_v) qa.push_back({13'b0, a_addr, a_d});
        if (b_v) qb.push_back({20'b0, b_addr, b_d});
        if (a_irq != 4'b0) begin na_irq++; la_irq = a_irq; end
        if (b_irq != 4'b0) begin nb_irq++; lb_irq = b_irq; end
        if (a_err) na_err++;
        if (b_err) nb_err++;
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    // What a datagram should produce, from the header fields and byte counts alone.
    function automatic res_t model(input logic [3:0] pen, input logic [15:0] dst, len,
                                   input int nhdr, npay, fe, lim);
        res_t r;
        int plen, got;
        r.beats = 0; r.irqv = 4'b0; r.err = 0; r.acc = 1'b0; r.ch = 2'd0;
        if (fe == 0) return r;
        if (nhdr < 8) begin r.err = 1; return r; end
        for (int i = 0; i < 4; i++)
            if (!r.acc && pen[i] && port_list[16*i +: 16] == dst) begin r.acc = 1'b1; r.ch = 2'(i); end
        if (!r.acc) return r;
        if (len < 16'd8) begin r.acc = 1'b0; r.err = 1; return r; end
        plen = int'(len) - 8;
        got = npay < plen ? npay : plen;
        if (got > lim) begin r.beats = lim; r.err = 1; end
        else if (npay < plen) begin r.beats = npay; r.err = 1; end
        else begin r.beats = plen; r.irqv = 4'(1 << r.ch); end
        return r;
    endfunction

    task automatic snap();
        ba_q = qa.size(); bb_q = qb.size(); ba_i = na_irq; bb_i = nb_irq; ba_e = na_err; bb_e = nb_err;
    endtask

    task automatic send(input logic [3:0] pen, input logic [15:0] dst, src, len,
                        input int nhdr, npay, fe, input logic same, rnd);
        logic [63:0] hdr;
        logic [7:0] by[$];
        hdr = {src, dst, len, 16'hC0DE};
        pl.delete();
        for (int k = 0; k < npay; k++) pl.push_back(rnd ? 8'($urandom) : pat[k % 4] + 8'(k / 4));
        for (int j = 0; j < nhdr; j++) by.push_back(hdr[63-8*j -: 8]);
        if (nhdr == 8) foreach (pl[k]) by.push_back(pl[k]);
        port_en = pen;
        func_en = fe != 0;
        for (int j = 0; j < by.size(); j++) begin
            @(negedge clk);
            v = 1'b1; d = by[j]; irq = same && j == by.size() - 1;
            if (fe == 2 && j == 1) func_en = 1'b0;
        end
        @(negedge clk);
        v = 1'b0; d = 8'h00;
        if (!same) begin irq = 1'b1; @(negedge clk); end
        irq = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_dut(input string tag, input int w, input int eb, input logic [3:0] ei,
                             input int ee, input logic [1:0] ech);
        logic [31:0] q[$];
        int nb, ni, ne, base;
        logic [3:0] li;
        logic [1:0] ch;
        logic [15:0] s, l;
        string t;
        t = $sformatf("%s/dut%0d", tag, w);
        if (w == 0) begin
            q = qa; base = ba_q; nb = qa.size() - ba_q; ni = na_irq - ba_i; ne = na_err - ba_e;
            li = la_irq; ch = a_ch; s = a_src; l = a_len;
        end else begin
            q = qb; base = bb_q; nb = qb.size() - bb_q; ni = nb_irq - bb_i; ne = nb_err - bb_e;
            li = lb_irq; ch = b_ch; s = b_src; l = b_len;
        end
        chk({t, "/beats"}, 64'(nb), 64'(eb));
        for (int k = 0; k < nb && k < eb; k++)
            chk($sformatf("%s/beat%0d", t, k), 64'(q[base+k]), 64'({16'(k), 8'h00} | {16'h0, pl[k]}));
        chk({t, "/irq_pulses"}, 64'(ni), 64'(ei != 4'b0));
        if (ei != 4'b0) chk({t, "/irq_vec"}, 64'(li), 64'(ei));
        chk({t, "/err_pulses"}, 64'(ne), 64'(ee));
        chk({t, "/ch"}, 64'(ch), 64'(ech));
        chk({t, "/src"}, 64'(s), 64'(m_src));
        chk({t, "/len"}, 64'(l), 64'(m_len));
    endtask

    task automatic run_dg(input string tag, input logic [3:0] pen, input logic [15:0] dst, src, len,
                          input int nhdr, npay, fe, input logic same, rnd, tbl,
                          input int eb, input logic [3:0] ei, input int ee, input logic [1:0] ech);
        res_t ra, rb;
        ra = model(pen, dst, len, nhdr, npay, fe, 2048);
        rb = model(pen, dst, len, nhdr, npay, fe, 16);
        snap();
        send(pen, dst, src, len, nhdr, npay, fe, same, rnd);
        if (rb.acc) begin m_ch = rb.ch; m_src = src; m_len = len; end
        if (tbl) check_dut(tag, 0, eb, ei, ee, ech);
        else check_dut(tag, 0, ra.beats, ra.irqv, ra.err, m_ch);
        check_dut(tag, 1, rb.beats, rb.irqv, rb.err, m_ch);
    endtask

    initial begin
        logic [15:0] dsts[4];
        logic [15:0] ln;
        tv[0]  = '{4'b0001, 16'h1234, 16'd12,  8, 10, 1, 1'b0,  4, 4'b0001, 0, 2'd0};
        tv[1]  = '{4'b0110, 16'h0050, 16'd10,  8,  2, 1, 1'b0,  2, 4'b0010, 0, 2'd1};
        tv[2]  = '{4'b0100, 16'h0050, 16'd9,   8,  1, 1, 1'b1,  1, 4'b0100, 0, 2'd2};
        tv[3]  = '{4'b0000, 16'h0050, 16'd12,  8,  4, 1, 1'b0,  0, 4'b0000, 0, 2'd2};
        tv[4]  = '{4'b0001, 16'h1234, 16'd100, 8, 20, 1, 1'b0, 20, 4'b0000, 1, 2'd0};
        tv[5]  = '{4'b0001, 16'h1234, 16'd20,  5,  0, 1, 1'b0,  0, 4'b0000, 1, 2'd0};
        tv[6]  = '{4'b0001, 16'h1234, 16'd4,   8,  3, 1, 1'b0,  0, 4'b0000, 1, 2'd0};
        tv[7]  = '{4'b0001, 16'h1234, 16'd8,   8,  2, 1, 1'b0,  0, 4'b0001, 0, 2'd0};
        tv[8]  = '{4'b0001, 16'h1234, 16'd8,   8,  0, 1, 1'b1,  0, 4'b0001, 0, 2'd0};
        tv[9]  = '{4'b0001, 16'h1234, 16'd12,  8,  4, 0, 1'b0,  0, 4'b0000, 0, 2'd0};
        tv[10] = '{4'b1000, 16'hBEEF, 16'd11,  8,  3, 2, 1'b0,  3, 4'b1000, 0, 2'd3};
        tv[11] = '{4'b1111, 16'h9999, 16'd12,  8,  4, 1, 1'b0,  0, 4'b0000, 0, 2'd3};
        tv[12] = '{4'b0001, 16'h1234, 16'd28,  8, 20, 1, 1'b0, 20, 4'b0001, 0, 2'd0};
        tv[13] = '{4'b0001, 16'h1234, 16'd24,  8, 16, 1, 1'b1, 16, 4'b0001, 0, 2'd0};
        dsts = '{16'h1234, 16'h0050, 16'hBEEF, 16'h7777};

        rst = 1'b1; func_en = 1'b0; v = 1'b0; irq = 1'b0; d = 8'h00; port_en = 4'b0;
        repeat (2) @(negedge clk);
        chk("reset_a", 64'({a_v, a_d, a_ch, a_addr, a_src, a_len, a_irq, a_err}), 64'd0);
        chk("reset_b", 64'({b_v, b_d, b_ch, b_addr, b_src, b_len, b_irq, b_err}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_dg($sformatf("vec%0d", i), tv[i].pen, tv[i].dst, 16'hA000 + 16'(i), tv[i].len,
                   tv[i].nhdr, tv[i].npay, tv[i].fe, tv[i].same, 1'b0, 1'b1,
                   tv[i].e_beats, tv[i].e_irq, tv[i].e_err, tv[i].e_ch);

        for (int i = 0; i < 40; i++) begin
            case ($urandom % 4)
                0: ln = 16'($urandom_range(0, 40));
                1: ln = 16'd8;
                2: ln = 16'($urandom % 8);
                default: ln = 16'(8 + $urandom_range(10, 30));
            endcase
            run_dg($sformatf("rnd%0d", i), 4'($urandom), dsts[$urandom % 4], 16'($urandom), ln,
                   ($urandom % 6 == 0) ? $urandom_range(1, 7) : 8, $urandom_range(0, 34),
                   ($urandom % 8 == 0) ? 0 : (($urandom % 8 == 0) ? 2 : 1),
                   1'($urandom), 1'b1, 1'b0, 0, 4'b0, 0, 2'd0);
        end

        // Reset lands between clock edges while payload is streaming.
        port_en = 4'b0001; func_en = 1'b1;
        send(4'b0001, 16'h1234, 16'h5555, 16'd40, 8, 0, 1, 1'b1, 1'b1);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            v = 1'b1; d = 8'(j * 7 + 1);
            if (j < 8) d = j == 2 ? 8'h12 : j == 3 ? 8'h34 : j == 5 ? 8'd40 : 8'h00;
        end
        @(posedge clk);
        #3 rst = 1'b1; v = 1'b0; d = 8'h00;
        #1;
        chk("midreset_a", 64'({a_v, a_d, a_ch, a_addr, a_src, a_len, a_irq, a_err}), 64'd0);
        chk("midreset_b", 64'({b_v, b_d, b_ch, b_addr, b_src, b_len, b_irq, b_err}), 64'd0);
`ifdef RX_UDP_STATS_EN
        chk("stats_reset", 64'({a_fc[31:0], a_ec}), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        m_ch = 2'd0; m_src = 16'h0; m_len = 16'h0;
        repeat (2) @(negedge clk);
        run_dg("post_reset", 4'b0001, 16'h1234, 16'hAAAA, 16'd13, 8, 5, 1, 1'b0, 1'b1, 1'b1,
               5, 4'b0001, 0, 2'd0);
`ifdef RX_UDP_STATS_EN
        chk("stats_frame_a", 64'(a_fc[15:0]), 64'd1);
        chk("stats_err_a", 64'(a_ec), 64'd0);
        chk("stats_frame_b", 64'(b_fc[15:0]), 64'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
